// File: rtl/debounce_sync.sv
// debounce_sync: per-channel 2-FF synchronizer plus stable-count debounce filter,
// producing a clean level, one-cycle rise/fall strobes and a press-toggle bit.
module debounce_sync #(
    parameter int WIDTH = 4,
    parameter int COUNT_MAX = 16,
    parameter int CNT_W = $clog2(COUNT_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] toggle
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT_MAX - 1);

    logic [WIDTH-1:0] sync1, s, commit;
    logic [WIDTH-1:0][CNT_W-1:0] cnt, cntNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cntNext;
    end

    // A nonzero count means a change is pending; any match with level discards it.
    always_comb begin
        commit  = '0;
        cntNext = '0;
        for (int i = 0; i < WIDTH; i++) begin
            commit[i]  = (s[i] != level[i]) && (cnt[i] == LAST);
            cntNext[i] = (s[i] == level[i] || commit[i]) ? '0 : cnt[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= '0;
            rise   <= '0;
            fall   <= '0;
            toggle <= '0;
        end else begin
            level  <= (level & ~commit) | (s & commit);
            rise   <= commit & s;
            fall   <= commit & ~s;
            toggle <= toggle ^ (commit & s);
        end
    end
endmodule
